// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with MIPS-style HI/LO results.
// Multiplies use shift-add and divides use restoring subtraction. Both work on
// operand magnitudes, one step per cycle for WIDTH cycles. The signs are fixed
// up when the result is written to hi/lo.
// Optional feature: define MUL_DIV_UNIT_UNSIGNED_EN so that op[0] selects the
// unsigned MULTU/DIVU forms. Without it, every operation is signed.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    // Magnitude of a two's-complement operand. The most-negative value maps to
    // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic neg);
        logic signed [WIDTH-1:0] n;
        n = -v;
        return neg ? $unsigned(n) : $unsigned(v);
    endfunction

    // Applies the sign to a WIDTH-bit magnitude result.
    function automatic logic [WIDTH-1:0] apply_sign_w(input logic [WIDTH-1:0] v,
                                                      input logic neg);
        return neg ? -v : v;
    endfunction

    // Applies the sign to the full double-width product.
    function automatic logic [2*WIDTH-1:0] apply_sign_2w(input logic [2*WIDTH-1:0] v,
                                                         input logic neg);
        return neg ? -v : v;
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] step_cnt;
    logic             dz_flag;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_is_zero;

`ifdef MUL_DIV_UNIT_UNSIGNED_EN
    assign signed_op = ~op[0];
`else
    logic unused_op0;
    assign unused_op0 = op[0];
    assign signed_op  = 1'b1;
`endif

    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = magnitude($signed(a), a_neg);
    assign b_mag     = magnitude($signed(b), b_neg);
    assign b_is_zero = (b == '0);
    assign busy      = (state == RUN) || (state == FINISH);

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? dvsr : '0)};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, dvsr});
        step_hi   = mul_sum[WIDTH:1];
        step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            // A remainder below the divisor always fits in WIDTH bits, so
            // dropping the top bit of the subtraction is exact.
            step_hi = div_ge ? (div_shift[WIDTH-1:0] - dvsr) : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end
    end

    // Sign correction of the final magnitude results before they go to hi/lo.
    always_comb begin
        prod   = apply_sign_2w({acc_hi, acc_lo}, neg_res);
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            res_hi = apply_sign_w(acc_hi, neg_rem);
            res_lo = apply_sign_w(acc_lo, neg_res);
        end
    end

    // Control FSM: sequences IDLE -> RUN (WIDTH steps) -> FINISH and produces the done/div_zero pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            step_cnt <= '0;
            dz_flag  <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        step_cnt <= '0;
                        dz_flag  <= op[1] & b_is_zero;
                        state    <= (op[1] && b_is_zero) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    step_cnt <= step_cnt + CNT_W'(1);
                    if (step_cnt == LAST_STEP) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    done     <= 1'b1;
                    div_zero <= dz_flag;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: latches operands on an accepted start, iterates during RUN and writes hi/lo in FINISH.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dvsr    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        acc_hi  <= '0;
                        // Divide shifts the dividend through acc_lo. Multiply
                        // shifts the multiplier out of acc_lo.
                        acc_lo  <= op[1] ? a_mag : b_mag;
                        dvsr    <= op[1] ? b_mag : a_mag;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                end
                FINISH: begin
                    if (!dz_flag) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit. It drives a WIDTH=32 instance and a WIDTH=8
// instance and compares them with an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start32, start8;
    logic [1:0]  op32, op8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, dz32, busy8, done8, dz8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;

    int ncmp  = 0;
    int nfail = 0;
    logic [31:0] mhi[2];
    logic [31:0] mlo[2];

    mul_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on w-bit operands.
    function automatic void model(input int w, input logic [1:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] phi, input logic [31:0] plo,
                                  output logic [31:0] ehi, output logic [31:0] elo,
                                  output logic edz);
        longint mask, ua, ub, sa, sb, p, q, r;
        bit uns;
        uns = op[0];
`ifndef MUL_DIV_UNIT_UNSIGNED_EN
        uns = 1'b0;
`endif
        mask = (64'sd1 <<< w) - 64'sd1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = ((ua >> (w - 1)) & 64'sd1) != 0 ? ua - (64'sd1 <<< w) : ua;
        sb = ((ub >> (w - 1)) & 64'sd1) != 0 ? ub - (64'sd1 <<< w) : ub;
        edz = 1'b0;
        ehi = phi;
        elo = plo;
        if (!op[1]) begin
            p   = uns ? ua * ub : sa * sb;
            ehi = 32'((p >> w) & mask);
            elo = 32'(p & mask);
        end else if (ub == 0) begin
            edz = 1'b1;
        end else begin
            q   = uns ? ua / ub : sa / sb;
            r   = uns ? ua % ub : sa % sb;
            elo = 32'(q & mask);
            ehi = 32'(r & mask);
        end
    endfunction

    task automatic drive(input bit w8, input logic s, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = s; op32 = op; a32 = a; b32 = b;
        end
    endtask

    function automatic logic obs_busy(input bit w8);
        return w8 ? busy8 : busy32;
    endfunction
    function automatic logic obs_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction
    function automatic logic obs_dz(input bit w8);
        return w8 ? dz8 : dz32;
    endfunction
    function automatic logic [31:0] obs_hi(input bit w8);
        return w8 ? {24'b0, hi8} : hi32;
    endfunction
    function automatic logic [31:0] obs_lo(input bit w8);
        return w8 ? {24'b0, lo8} : lo32;
    endfunction

    // Issues one operation and waits for done. The operands are scrambled
    // after the start cycle. If inj > 0, a second start is pulsed in that
    // cycle. The task returns in the done cycle.
    task automatic run_op(input bit w8, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inj);
        int         w;
        int         cyc;
        bit         got;
        logic [31:0] ehi, elo;
        logic       edz;
        w = w8 ? 8 : 32;
        model(w, op, a, b, mhi[w8], mlo[w8], ehi, elo, edz);
        drive(w8, 1'b1, op, a, b);
        cyc = 0;
        got = 0;
        while (!got && cyc < w + 10) begin
            step;
            cyc++;
            drive(w8, 1'b0, 2'($urandom), $urandom, $urandom);
            if (cyc == inj) drive(w8, 1'b1, 2'($urandom), $urandom, $urandom | 32'h1);
            if (cyc == 1) begin
                check("busy_after_start", 64'(obs_busy(w8)), 64'd1);
                check("hi_hold_in_run", 64'(obs_hi(w8)), 64'(mhi[w8]));
                check("lo_hold_in_run", 64'(obs_lo(w8)), 64'(mlo[w8]));
            end
            got = obs_done(w8);
        end
        drive(w8, 1'b0, op, a, b);
        check("done_latency", 64'(cyc), edz ? 64'd2 : 64'(w + 2));
        check("div_zero", 64'(obs_dz(w8)), 64'(edz));
        check("hi", 64'(obs_hi(w8)), 64'(ehi));
        check("lo", 64'(obs_lo(w8)), 64'(elo));
        check("busy_at_done", 64'(obs_busy(w8)), 64'd0);
        mhi[w8] = ehi;
        mlo[w8] = elo;
    endtask

    // One cycle after done: the pulses are gone and no operation has started.
    task automatic idle_check(input bit w8);
        step;
        check("done_single_pulse", 64'(obs_done(w8)), 64'd0);
        check("dz_single_pulse", 64'(obs_dz(w8)), 64'd0);
        check("busy_idle", 64'(obs_busy(w8)), 64'd0);
    endtask

    initial begin
        int dcount;
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
        mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
        step;
        step;
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_done", 64'(done32), 64'd0);
        check("rst_dz", 64'(dz32), 64'd0);
        check("rst_hi", 64'(hi32), 64'd0);
        check("rst_lo", 64'(lo32), 64'd0);
        check("rst_hi8", 64'(hi8), 64'd0);
        reset = 1'b0;

        // Directed cases, starting in the first cycle after reset.
        run_op(1'b0, 2'b00, 32'hFFFFFFFD, 32'd7, -1);
        idle_check(1'b0);
        run_op(1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        idle_check(1'b0);
        run_op(1'b0, 2'b10, 32'hFFFFFFF9, 32'd2, -1);
        idle_check(1'b0);
        run_op(1'b0, 2'b10, 32'h80000000, 32'hFFFFFFFF, -1);
        idle_check(1'b0);
        run_op(1'b0, 2'b10, 32'h451, 32'h20, -1);
        check("prior_hi", 64'(hi32), 64'h11);
        check("prior_lo", 64'(lo32), 64'h22);
        idle_check(1'b0);
        run_op(1'b0, 2'b10, 32'd5, 32'd0, -1);
        idle_check(1'b0);
        run_op(1'b0, 2'b11, 32'd5, 32'd0, -1);
        idle_check(1'b0);
        run_op(1'b0, 2'b00, 32'h12345678, 32'h9ABCDEF0, 5);
        idle_check(1'b0);
        run_op(1'b0, 2'b10, 32'h7FFFFFFF, 32'hFFFFFFFD, 33);
        idle_check(1'b0);
        // Back-to-back: the next start falls in the done cycle.
        run_op(1'b0, 2'b00, 32'd1000, 32'hFFFFFC18, -1);
        run_op(1'b0, 2'b11, 32'hF0000000, 32'd3, -1);
        idle_check(1'b0);
        run_op(1'b1, 2'b01, 32'd200, 32'd200, -1);
        idle_check(1'b1);
        run_op(1'b1, 2'b10, 32'h80, 32'hFF, -1);
        idle_check(1'b1);

        // Reset takes priority over a simultaneous start.
        reset = 1'b1;
        drive(1'b0, 1'b1, 2'b00, 32'd3, 32'd4);
        step;
        drive(1'b0, 1'b0, 2'b00, 32'd3, 32'd4);
        reset = 1'b0;
        check("rst_prio_busy", 64'(busy32), 64'd0);
        step;
        check("rst_prio_no_start", 64'(busy32), 64'd0);
        mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;

        run_op(1'b0, 2'b00, 32'd6, 32'd7, -1);
        idle_check(1'b0);

        // Reset in the middle of RUN aborts the operation and produces no done.
        drive(1'b0, 1'b1, 2'b00, 32'd11, 32'd13);
        step;
        drive(1'b0, 1'b0, 2'b00, 32'd11, 32'd13);
        repeat (9) step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_done", 64'(done32), 64'd0);
        check("abort_hi", 64'(hi32), 64'd0);
        check("abort_lo", 64'(lo32), 64'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            step;
            if (done32) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);
        mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;

        // Randomized operations on both widths.
        for (int i = 0; i < 24; i++) begin
            bit          w8;
            logic [1:0]  op;
            logic [31:0] a, b, bm;
            int          inj;
            w8 = (i % 4 == 0);
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) begin
                a = w8 ? 32'h80 : 32'h80000000;
                b = 32'hFFFFFFFF;
            end
            bm  = w8 ? (b & 32'hFF) : b;
            inj = -1;
            if (bm != 0 && $urandom_range(0, 2) == 0) inj = $urandom_range(2, w8 ? 9 : 33);
            run_op(w8, op, a, b, inj);
            if ($urandom_range(0, 1) == 0) idle_check(w8);
        end
        idle_check(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits (legal range 4..64).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request, sampled only while idle.
REQ-005 The block SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port a  input  WIDTH  multiplicand or dividend.
REQ-007 The block SHALL have port b  input  WIDTH  multiplier or divisor.
REQ-008 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have port div_zero  output  1  one-cycle pulse, coincident with done, for divisor zero.
REQ-011 The block SHALL have port hi  output  WIDTH  HI result register.
REQ-012 The block SHALL have port lo  output  WIDTH  LO result register.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, FINISH.
REQ-014 In IDLE with start=1, the block SHALL latch a, b, op, and enter RUN; busy SHALL rise the next cycle.
REQ-015 RUN SHALL last exactly WIDTH cycles (one shift-add or restoring-subtract step per cycle), then go to FINISH.
REQ-016 FINISH SHALL last one cycle; it SHALL write hi/lo, pulse done, drop busy, and return to IDLE.
REQ-017 done SHALL assert exactly WIDTH+2 cycles after the cycle in which start was sampled.
REQ-018 Multiply SHALL produce the full 2*WIDTH product, {hi,lo} = a*b, signed for MULT and unsigned for MULTU.
REQ-019 Divide SHALL write the quotient to lo and the remainder to hi.
REQ-020 Signed divide SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-021 Signed divide of the most-negative value by -1 SHALL yield lo = most-negative value and hi = 0, with no flag.
REQ-022 If the divisor is zero on a DIV/DIVU start, the block SHALL skip RUN and go directly to FINISH.
REQ-023 In the divisor-zero case, done and div_zero SHALL pulse together 2 cycles after start, and hi/lo SHALL keep their previous values.
REQ-024 start while busy SHALL be ignored, with no effect on the operation in progress or on its results.
REQ-025 start in the FINISH cycle SHALL be ignored.
REQ-026 start in the IDLE cycle immediately after FINISH SHALL be accepted.
REQ-027 hi/lo SHALL change only in FINISH and SHALL otherwise hold their values.
REQ-028 Changes to a, b, or op after the start cycle SHALL have no effect on the operation in progress.

Reset
REQ-029 When reset=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-030 Reset SHALL clear busy, done, div_zero, hi, lo, and all internal datapath registers to 0.
REQ-031 Reset SHALL take priority over start.
REQ-032 Reset asserted mid-RUN SHALL abort the operation without a done pulse.
REQ-033 The first start SHALL be accepted in the cycle after reset is deasserted.

Configuration
REQ-034 When the macro MUL_DIV_UNIT_UNSIGNED_EN is defined, op[0] SHALL select unsigned MULTU/DIVU as described above.
REQ-035 When MUL_DIV_UNIT_UNSIGNED_EN is undefined, op[0] SHALL be ignored and all operations SHALL be signed; no unsigned-correction logic SHALL be synthesised.

Verification
REQ-036 WIDTH=32, MULT a=-3 (0xFFFFFFFD), b=7 -> done at start+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-037 WIDTH=32, MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (with macro defined); without the macro -> hi=0, lo=1.
REQ-038 WIDTH=32, DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-039 WIDTH=32, DIV with prior hi=0x11, lo=0x22, a=5, b=0 -> done and div_zero high at start+2; hi=0x11, lo=0x22 unchanged.
REQ-040 WIDTH=32, a second start pulse issued mid-RUN -> ignored, and only one done pulse occurs with the first operation's result.
REQ-041 WIDTH=32, reset at start+10 -> no done pulse and busy=0, hi=lo=0 next cycle; WIDTH=8, MULTU 200*200 -> hi=0x9C, lo=0x40 at start+10.
